max_stream_sched: RTL

Sequential frame-based max-reduction controller. It time-shares one two-operand WIDTH-bit max unit, either the exact comparator or the approximate bmf-partitioned netlist, across a stream of operands. Each frame is accepted over a valid/ready handshake and reduced at one operand per cycle. Per frame it reports the maximum, its position and the frame length. It sits between an operand source and any consumer that evaluates exact versus approximate max error in-system.

---
 rtl/max_stream_sched_pkg.sv | 24 ++
 rtl/max_stream_sched_if.sv | 29 ++
 rtl/max_stream_sched_max_unit.sv | 35 +++
 rtl/max_stream_sched.sv | 112 +++++++++++
 4 files changed

// File: rtl/max_stream_sched_pkg.sv
// Shared definitions for the frame max-reduction controller.
// Contents: controller state encoding, default widths, the split point of the
// approximate max unit, and a saturating-increment helper for counters.
package max_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 8;

  // The approximate unit only compares bits above this many LSBs; the low
  // bits of equal-high operands are merged instead of compared.
  localparam int APPROX_LO_W = 2;

  // Increment that sticks at vmax instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/max_stream_sched_if.sv
// Operand/result bundle of max_stream_sched.
// Ports: operand stream (in_valid/in_ready/in_data/in_last) and frame result
// stream (out_valid/out_ready/out_max/out_idx/out_len/out_ovf).
// slave = the reduction block, master = the source/consumer side.
interface max_stream_sched_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_idx;
  logic [CNT_W-1:0] out_len;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_idx, out_len, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_idx, out_len, out_ovf
  );
endinterface

// File: rtl/max_stream_sched_max_unit.sv
// Two-operand max unit, exact comparator or approximate partitioned netlist.
// Ports: a, b (WIDTH-bit operands) -> y (WIDTH-bit result); purely combinational.
// The approximate form compares only the high bits and ORs the low bits on a tie.
module max_unit
  import max_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int APPROX = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  generate
    if (APPROX == 0) begin : g_exact
      assign y = (a >= b) ? a : b;
    end else begin : g_approx
      localparam int HI_W = WIDTH - APPROX_LO_W;
      logic [HI_W-1:0]        a_hi, b_hi;
      logic [APPROX_LO_W-1:0] a_lo, b_lo;

      assign a_hi = a[WIDTH-1:APPROX_LO_W];
      assign b_hi = b[WIDTH-1:APPROX_LO_W];
      assign a_lo = a[APPROX_LO_W-1:0];
      assign b_lo = b[APPROX_LO_W-1:0];

      // High partition decides; equal highs yield a merged value that need not
      // equal either operand.
      assign y = (a_hi > b_hi) ? a :
                 (b_hi > a_hi) ? b : {a_hi, a_lo | b_lo};
    end
  endgenerate

endmodule

// File: rtl/max_stream_sched.sv
// Frame max-reduction controller sharing one max unit across an operand stream.
// Ports: clk, rst (sync, active-high), bus (slave modport: operand in, result out).
// One operand per cycle; result valid the cycle after in_last; in_ready=0 while a result waits.
module max_stream_sched
  import max_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int APPROX = 0
) (
  input  logic            clk,
  input  logic            rst,
  max_stream_sched_if.slave bus
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [WIDTH-1:0] m;
  logic             xfer;
  logic             load_out;

  logic [WIDTH-1:0] out_max_q;
  logic [CNT_W-1:0] out_idx_q;
  logic [CNT_W-1:0] out_len_q;
  logic             out_ovf_q;

  max_unit #(.WIDTH(WIDTH), .APPROX(APPROX)) u_max (
    .a (acc),
    .b (bus.in_data),
    .y (m)
  );

  // in_ready depends on state only, never on out_ready.
  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign xfer          = bus.in_valid && (state != HOLD);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    idx_n   = idx;
    cnt_n   = cnt;
    ovf_n   = ovf;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          acc_n   = bus.in_data;
          idx_n   = '0;
          cnt_n   = CNT_W'(1);
          ovf_n   = 1'b0;
          state_n = bus.in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (xfer) begin
          acc_n = m;
          // Only a strict change that came from the new operand moves the
          // index, so ties keep the earliest position.
          if ((m != acc) && (m == bus.in_data)) idx_n = cnt;
          cnt_n = CNT_W'(sat_inc(32'(cnt), CNT_MAX));
          if (32'(cnt) == CNT_MAX) ovf_n = 1'b1;
          if (bus.in_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result registers are loaded on HOLD entry so they keep the last frame's
  // values after handoff while the next frame is being accumulated.
  assign load_out = (state != HOLD) && (state_n == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_max_q <= '0;
      out_idx_q <= '0;
      out_len_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      if (load_out) begin
        out_max_q <= acc_n;
        out_idx_q <= idx_n;
        out_len_q <= cnt_n;
        out_ovf_q <= ovf_n;
      end
    end
  end

  assign bus.out_max = out_max_q;
  assign bus.out_idx = out_idx_q;
  assign bus.out_len = out_len_q;
  assign bus.out_ovf = out_ovf_q;

endmodule
